// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and constants for the decoder_pipe slice.
package decoder_pkg;

  // Command mode carried on in_mode.
  typedef enum logic {
    DEC_DIRECT = 1'b0,
    DEC_SWEEP  = 1'b1
  } dec_mode_e;

  // Control FSM states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } dec_state_e;

  // Width of the optional output-transfer counter.
  localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/decoder_onehot.sv
// decoder_onehot: combinational IN_W-to-2^IN_W one-hot decoder with enable
// and selectable output polarity (inversion applied after decode).
module decoder_onehot #(
  parameter int IN_W       = 3,
  parameter int ACTIVE_LOW = 0
) (
  input  logic [IN_W-1:0]      code,
  input  logic                 en,
  output logic [(2**IN_W)-1:0] lines
);

  logic [(2**IN_W)-1:0] raw;

  // Decode the code to an active-high one-hot word, all-zero when disabled.
  always_comb begin
    raw = {(2**IN_W){1'b0}};
    if (en) begin
      raw[code] = 1'b1;
    end else begin
      raw = {(2**IN_W){1'b0}};
    end
  end

  // Apply output polarity; the inactive word is inverted along with the rest.
  always_comb begin
    if (ACTIVE_LOW != 0) begin
      lines = ~raw;
    end else begin
      lines = raw;
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered binary-to-one-hot decoder with valid/ready on both
// sides and a sweep mode emitting one-hot(0)..one-hot(end) as separate beats.
// Optional feature macro: DECODER_BEAT_CNT_EN adds a 16-bit saturating
// count of output transfers on port beat_cnt.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter  int IN_W       = 3,
  parameter  int ACTIVE_LOW = 0,
  localparam int OUT_W      = 2**IN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_code,
  input  logic                  in_en,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      d_out,
`ifdef DECODER_BEAT_CNT_EN
  output logic [BEAT_CNT_W-1:0] beat_cnt,
`endif
  output logic                  sweep_last
);

  localparam logic [OUT_W-1:0] INACTIVE =
    (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  dec_state_e       state;
  dec_state_e       next_state;
  logic [IN_W-1:0]  count;
  logic [IN_W-1:0]  count_inc;
  logic [IN_W-1:0]  end_code;
  logic             sweep_en;
  logic             in_xfer;
  logic             out_xfer;
  logic             sweep_cmd;
  logic             sweep_done;
  logic [IN_W-1:0]  dec_code;
  logic             dec_en;
  logic             load_last;
  logic [OUT_W-1:0] dec_lines;

  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;
  assign sweep_cmd  = (dec_mode_e'(in_mode) == DEC_SWEEP);
  assign count_inc  = count + IN_W'(1);
  assign sweep_done = (count == end_code);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state: a sweep command enters SWEEP, the final beat's transfer exits.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (in_xfer && sweep_cmd) begin
          next_state = ST_SWEEP;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (out_xfer && sweep_done) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_SWEEP;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: input acceptance and the code/enable fed to the decoder.
  always_comb begin
    in_ready  = 1'b0;
    dec_code  = {IN_W{1'b0}};
    dec_en    = 1'b0;
    load_last = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !rst && (!out_valid || out_ready);
        dec_en   = in_en;
        if (sweep_cmd) begin
          // First sweep beat is always code 0; it is also the last when end=0.
          dec_code  = {IN_W{1'b0}};
          load_last = (in_code == {IN_W{1'b0}});
        end else begin
          dec_code  = in_code;
          load_last = 1'b0;
        end
      end
      ST_SWEEP: begin
        // Decode the beat that follows the one currently held.
        in_ready  = 1'b0;
        dec_code  = count_inc;
        dec_en    = sweep_en;
        load_last = (count_inc == end_code);
      end
      default: begin
        in_ready  = 1'b0;
        dec_code  = {IN_W{1'b0}};
        dec_en    = 1'b0;
        load_last = 1'b0;
      end
    endcase
  end

  decoder_onehot #(
    .IN_W       (IN_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_onehot (
    .code  (dec_code),
    .en    (dec_en),
    .lines (dec_lines)
  );

  // Sweep bookkeeping: latch end code and enable, step the beat index per transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= {IN_W{1'b0}};
      end_code <= {IN_W{1'b0}};
      sweep_en <= 1'b0;
    end else if (in_xfer && sweep_cmd) begin
      count    <= {IN_W{1'b0}};
      end_code <= in_code;
      sweep_en <= in_en;
    end else if ((state == ST_SWEEP) && out_xfer) begin
      if (sweep_done) begin
        count <= {IN_W{1'b0}};
      end else begin
        count <= count_inc;
      end
    end else begin
      count <= count;
    end
  end

  // Single output register: loads when empty or when its beat leaves this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      d_out      <= INACTIVE;
      sweep_last <= 1'b0;
    end else if (in_xfer) begin
      out_valid  <= 1'b1;
      d_out      <= dec_lines;
      sweep_last <= load_last;
    end else if ((state == ST_SWEEP) && out_xfer) begin
      if (sweep_done) begin
        out_valid  <= 1'b0;
        sweep_last <= 1'b0;
      end else begin
        out_valid  <= 1'b1;
        d_out      <= dec_lines;
        sweep_last <= load_last;
      end
    end else if (out_xfer) begin
      out_valid  <= 1'b0;
      sweep_last <= 1'b0;
    end else begin
      out_valid  <= out_valid;
      sweep_last <= sweep_last;
    end
  end

`ifdef DECODER_BEAT_CNT_EN
  // Saturating count of output transfers, inactive beats included.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= {BEAT_CNT_W{1'b0}};
    end else if (out_xfer && (beat_cnt != {BEAT_CNT_W{1'b1}})) begin
      beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
    end else begin
      beat_cnt <= beat_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed self-checking bench for decoder_pipe.
// Instance u_dut uses IN_W=3 active-high; u_dut_al uses IN_W=4 ACTIVE_LOW=1.
module tb_decoder_pipe;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_code;
  logic        in_en;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  d_out;
  logic        sweep_last;

  logic        al_in_valid;
  logic        al_in_ready;
  logic [3:0]  al_in_code;
  logic        al_in_en;
  logic        al_in_mode;
  logic        al_out_valid;
  logic        al_out_ready;
  logic [15:0] al_d_out;
  logic        al_sweep_last;

`ifdef DECODER_BEAT_CNT_EN
  logic [15:0] beat_cnt;
  logic [15:0] al_beat_cnt;
`endif

  int n_cmp;
  int n_err;

  decoder_pipe #(.IN_W(3), .ACTIVE_LOW(0)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_en      (in_en),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d_out      (d_out),
`ifdef DECODER_BEAT_CNT_EN
    .beat_cnt   (beat_cnt),
`endif
    .sweep_last (sweep_last)
  );

  decoder_pipe #(.IN_W(4), .ACTIVE_LOW(1)) u_dut_al (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (al_in_valid),
    .in_ready   (al_in_ready),
    .in_code    (al_in_code),
    .in_en      (al_in_en),
    .in_mode    (al_in_mode),
    .out_valid  (al_out_valid),
    .out_ready  (al_out_ready),
    .d_out      (al_d_out),
`ifdef DECODER_BEAT_CNT_EN
    .beat_cnt   (al_beat_cnt),
`endif
    .sweep_last (al_sweep_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a sweep to endc and follow it; stall_mask bit c holds out_ready low on cycle c.
  task automatic sweep_run(input string tag, input int endc, input logic en, input logic [31:0] stall_mask);
    int k;
    int cyc;
    logic [7:0] exp_beat;
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_code   = 3'(endc);
    in_en     = en;
    out_ready = 1'b1;
    #1;
    check({tag, "_accept_rdy"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    k   = 0;
    cyc = 0;
    while ((k <= endc) && (cyc < 64)) begin
      out_ready = (cyc < 32) ? !stall_mask[cyc] : 1'b1;
      exp_beat  = en ? (8'd1 << k) : 8'd0;
      #1;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
      check({tag, "_beat"}, 32'(d_out), 32'(exp_beat));
      check({tag, "_last"}, 32'(sweep_last), (k == endc) ? 32'd1 : 32'd0);
      step();
      if (out_ready) k = k + 1;
      cyc = cyc + 1;
    end
    out_ready = 1'b1;
    #1;
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_rdy"}, 32'(in_ready), 32'd1);
    check({tag, "_beats"}, 32'(k), 32'(endc + 1));
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_code      = 3'd0;
    in_en        = 1'b1;
    in_mode      = 1'b0;
    out_ready    = 1'b1;
    al_in_valid  = 1'b0;
    al_in_code   = 4'd0;
    al_in_en     = 1'b1;
    al_in_mode   = 1'b0;
    al_out_ready = 1'b1;

    // Reset state on both instances.
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(d_out), 32'h00);
    check("rst_last", 32'(sweep_last), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_al_dout", 32'(al_d_out), 32'hFFFF);
`ifdef DECODER_BEAT_CNT_EN
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_rdy", 32'(in_ready), 32'd1);

    // Direct mode, every code back to back.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_en    = 1'b1;
      in_code  = 3'(i);
      #1;
      check("dir_rdy", 32'(in_ready), 32'd1);
      step();
      check("dir_valid", 32'(out_valid), 32'd1);
      check("dir_dout", 32'(d_out), 32'(8'd1 << i));
      check("dir_last", 32'(sweep_last), 32'd0);
    end
    in_valid = 1'b0;
    step();
    check("dir_drain", 32'(out_valid), 32'd0);
`ifdef DECODER_BEAT_CNT_EN
    check("dir_beat_cnt", 32'(beat_cnt), 32'd8);
`endif

    // Backpressure in direct mode.
    in_valid  = 1'b1;
    in_code   = 3'd5;
    out_ready = 1'b0;
    step();
    in_code = 3'd2;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_dout", 32'(d_out), 32'h20);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), 32'd1);
    step();
    check("bp_next_dout", 32'(d_out), 32'h04);
    in_valid = 1'b0;
    step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Sweeps: stall on the second beat, single beat, full range, disabled.
    sweep_run("sw3", 3, 1'b1, 32'h0000_0002);
    sweep_run("sw0", 0, 1'b1, 32'h0000_0000);
    sweep_run("sw7", 7, 1'b1, 32'h0000_0000);
    sweep_run("sw7_off", 7, 1'b0, 32'h0000_0000);

    // Active-low instance.
    al_in_valid = 1'b1;
    al_in_code  = 4'd9;
    al_in_en    = 1'b1;
    step();
    check("al_code9", 32'(al_d_out), 32'hFDFF);
    al_in_en = 1'b0;
    step();
    check("al_en0", 32'(al_d_out), 32'hFFFF);
    check("al_en0_valid", 32'(al_out_valid), 32'd1);
    al_in_valid = 1'b0;
    step();

    // Reset in the middle of a sweep to 7.
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_code   = 3'd7;
    in_en     = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_beat2", 32'(d_out), 32'h04);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", 32'(in_ready), 32'd0);
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_dout", 32'(d_out), 32'h00);
    check("mid_rst_last", 32'(sweep_last), 32'd0);
`ifdef DECODER_BEAT_CNT_EN
    check("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
    rst = 1'b0;
    in_mode = 1'b0;
    #1;
    check("mid_idle_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_code  = 3'd1;
    step();
    check("mid_direct", 32'(d_out), 32'h02);
    in_valid = 1'b0;
    step();
    check("mid_drain", 32'(out_valid), 32'd0);
`ifdef DECODER_BEAT_CNT_EN
    check("mid_beat_cnt", 32'(beat_cnt), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
Parametrised, registered binary-to-one-hot decoder with valid/ready handshakes on both sides.
It generalises the 3-to-8 combinational decoder to IN_W-to-2^IN_W with a selectable output polarity and a per-beat enable. It adds a sweep mode that emits every one-hot code from 0 up to a requested code as consecutive output beats.
It sits between a command source and per-line strobe consumers, such as chip-selects or register-bank write enables.

Parameters:
- IN_W, 3, width of the binary code.
- OUT_W, 2**IN_W, output width; localparam, not overridable.
- ACTIVE_LOW, 0, 1 inverts d_out, so the selected line is 0 and idle is all-ones.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a command is offered.
- in_ready  output  1  the block accepts the command this cycle.
- in_code  input  IN_W  binary code (direct), or the sweep end code (sweep).
- in_en  input  1  0 gives an all-inactive output beat for this command.
- in_mode  input  1  0 = direct, 1 = sweep.
- out_valid  output  1  d_out holds a beat.
- out_ready  input  1  the consumer takes the beat.
- d_out  output  OUT_W  registered decoded lines.
- sweep_last  output  1  qualifies the final beat of a sweep; high only while out_valid.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, sweep_last=0, state=IDLE, sweep counter=0.
  - d_out is the inactive value: all-0, or all-1 when ACTIVE_LOW=1.
  - in_ready is 0 while rst=1.
- Handshakes:
  - Input transfer is in_valid&in_ready; output transfer is out_valid&out_ready.
  - out_valid, d_out and sweep_last hold stable until the output transfer.
  - in_valid may drop without acceptance.
- Output stage: a single register. It loads when empty or when the output transfers in the same cycle.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational from state, out_valid and out_ready.
- Direct mode (in_mode=0):
  - On acceptance, the next edge loads d_out with one-hot(in_code), or inactive if in_en=0.
  - out_valid=1 and sweep_last=0. Latency is 1 cycle.
  - Back-to-back full throughput: one command per cycle while out_ready=1.
- Sweep mode (in_mode=1):
  - On acceptance, latch end=in_code and en=in_en; state goes IDLE->SWEEP; counter=0.
  - The beat for counter=0 loads on that same edge.
  - In SWEEP, each output transfer advances the counter and loads the next beat.
  - Beat k = one-hot(k), or inactive if en=0. sweep_last=1 on beat k==end.
  - When the k==end beat transfers: SWEEP->IDLE and the counter clears.
  - end=0 gives a single beat with sweep_last=1. end=OUT_W-1 gives OUT_W beats; the counter never wraps.
  - in_ready=0 throughout SWEEP.
- ACTIVE_LOW: inversion is applied after decode. The inactive value is also inverted.
- Reset mid-sweep or mid-hold: the beat is discarded and the reset values apply; no partial completion.
- X/out-of-range: not possible for in_code because the width is exact.
- States: IDLE, SWEEP.

Optional Feature:
DECODER_BEAT_CNT_EN
- Defined: adds output port beat_cnt (16 bits).
  - It counts output transfers, saturates at 16'hFFFF and clears on rst.
  - Inactive (in_en=0) beats are counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package decoder_pkg holds:
  - typedef dec_mode_e {DEC_DIRECT=1'b0, DEC_SWEEP=1'b1};
  - typedef dec_state_e {ST_IDLE, ST_SWEEP};
  - localparam BEAT_CNT_W=16.
- Sub-module decoder_onehot: combinational, params IN_W and ACTIVE_LOW, inputs code and en, output OUT_W lines. It is instantiated once and fed by a mux of in_code and the sweep counter.

Test Plan:
- Direct all codes, IN_W=3, out_ready=1:
  - Drive in_code 0..7 on consecutive cycles.
  - d_out is 8'h01,02,04,…,80, each one cycle after acceptance; in_ready is stuck at 1; 8 beats in 8 cycles.
- Backpressure, direct:
  - Send code 5 with out_ready=0 for 4 cycles, then offer code 2.
  - d_out holds 8'h20 with out_valid=1 and in_ready=0.
  - On the cycle out_ready=1, code 2 is accepted; the next cycle shows d_out=8'h04.
- Sweep to 3 with out_ready toggling 1,0,1,1,1:
  - Beats are 8'h01,02,04,08, with 8'h02 held through the stall.
  - sweep_last=1 only on 8'h08; in_ready=0 until that transfer, then 1.
- Sweep edges:
  - end=0 gives one beat 8'h01 with sweep_last=1.
  - end=7 gives 8 beats ending 8'h80 with last=1 and no wrap.
  - in_en=0 gives inactive beats with the same count.
- ACTIVE_LOW=1, IN_W=4:
  - Reset gives d_out=16'hFFFF.
  - Code 9 gives 16'hFDFF.
  - in_en=0 gives 16'hFFFF.
- Reset mid-sweep and counter:
  - Assert rst during beat 2 of a sweep to 7: next edge out_valid=0, state IDLE, in_ready=1 after rst falls.
  - With DECODER_BEAT_CNT_EN defined, beat_cnt=0 after reset and increments by 1 per output transfer.
